// File: rtl/instr_loader.sv
// instr_loader: packs a valid/ready byte stream little-endian into 32-bit
// words and writes them to instruction memory at BASE_ADDR + 4*i.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte (CSUM state) that decides between DONE and ERR.
module instr_loader #(
  parameter int unsigned MEM_SIZE  = 1024,
  parameter logic [63:0] BASE_ADDR = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] num_words,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [63:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_DONE = 3'd2,
    S_ERR  = 3'd3
`ifdef LOADER_CHECKSUM_EN
    , S_CSUM = 3'd4
`endif
  } state_t;

  state_t      state, state_n;
  logic [15:0] num_q, num_n;
  logic [15:0] word_idx, word_idx_n;
  logic [1:0]  byte_cnt, byte_cnt_n;
  logic [23:0] acc, acc_n;
  logic        wr_en_n, done_n, error_n, busy_n;
  logic [63:0] wr_addr_n;
  logic [31:0] wr_data_n;
  logic        accept;
  logic        too_big;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum, csum_n;
`endif

  assign accept  = byte_valid && byte_ready;
  assign too_big = (BASE_ADDR + {46'd0, num_words, 2'b00}) > 64'(MEM_SIZE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state, datapath and output-next logic
  always_comb begin
    state_n    = state;
    num_n      = num_q;
    word_idx_n = word_idx;
    byte_cnt_n = byte_cnt;
    acc_n      = acc;
    wr_en_n    = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    done_n     = done;
    error_n    = error;
`ifdef LOADER_CHECKSUM_EN
    csum_n     = csum;
`endif
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          done_n     = 1'b0;
          error_n    = 1'b0;
          word_idx_n = 16'd0;
          byte_cnt_n = 2'd0;
          num_n      = num_words;
`ifdef LOADER_CHECKSUM_EN
          csum_n     = 8'h00;
`endif
          if (num_words == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_n = S_CSUM;
`else
            state_n = S_DONE;
            done_n  = 1'b1;
`endif
          end else if (too_big) begin
            state_n = S_ERR;
            error_n = 1'b1;
          end else begin
            state_n = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          byte_cnt_n = byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_n     = csum ^ byte_in;
`endif
          case (byte_cnt)
            2'd0: acc_n[7:0]   = byte_in;
            2'd1: acc_n[15:8]  = byte_in;
            2'd2: acc_n[23:16] = byte_in;
            default: begin
              wr_en_n    = 1'b1;
              wr_addr_n  = BASE_ADDR + {46'd0, word_idx, 2'b00};
              wr_data_n  = {byte_in, acc};
              word_idx_n = word_idx + 16'd1;
              if (word_idx == num_q - 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                state_n = S_CSUM;
`else
                state_n = S_DONE;
                done_n  = 1'b1;
`endif
              end
            end
          endcase
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          if (byte_in == csum) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            state_n = S_ERR;
            error_n = 1'b1;
          end
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
`ifdef LOADER_CHECKSUM_EN
    busy_n = (state_n == S_LOAD) || (state_n == S_CSUM);
`else
    busy_n = (state_n == S_LOAD);
`endif
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_q      <= 16'd0;
      word_idx   <= 16'd0;
      byte_cnt   <= 2'd0;
      acc        <= 24'd0;
      wr_en      <= 1'b0;
      wr_addr    <= 64'd0;
      wr_data    <= 32'd0;
      done       <= 1'b0;
      error      <= 1'b0;
      busy       <= 1'b0;
      byte_ready <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= 8'h00;
`endif
    end else begin
      num_q      <= num_n;
      word_idx   <= word_idx_n;
      byte_cnt   <= byte_cnt_n;
      acc        <= acc_n;
      wr_en      <= wr_en_n;
      wr_addr    <= wr_addr_n;
      wr_data    <= wr_data_n;
      done       <= done_n;
      error      <= error_n;
      busy       <= busy_n;
      byte_ready <= busy_n;
`ifdef LOADER_CHECKSUM_EN
      csum       <= csum_n;
`endif
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares on every wr_en.
module tb_instr_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_words = 16'd0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready, wr_en, busy, done, error;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
    logic        done;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] xacc = 8'h00;

  instr_loader #(.MEM_SIZE(1024), .BASE_ADDR(64'd0)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
    check({tag, "_wr_en"},      64'(wr_en),      64'd0);
    check({tag, "_busy"},       64'(busy),       64'd0);
    check({tag, "_done"},       64'(done),       64'd0);
    check({tag, "_error"},      64'(error),      64'd0);
  endtask

  task automatic push_exp(input logic [63:0] a, input logic [31:0] d, input logic last);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.done = last && !CSUM;
    sb.push_back(e);
  endtask

  // All stimulus tasks are entered and left just after a negedge.
  task automatic start_load(input logic [15:0] n);
    start = 1'b1;
    num_words = n;
    xacc = 8'h00;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) check("byte_accept_timeout", 64'd0, 64'd1);
    xacc = xacc ^ b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic send_checksum();
    if (CSUM) send_byte(xacc);
  endtask

  task automatic wait_end();
    int t = 0;
    while (!(done || error) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("wait_end_timeout", 64'(done || error), 64'd1);
  endtask

  // Monitor: every write strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && wr_en) begin
      if (sb.size() == 0) begin
        check("spurious_wr_en", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", wr_addr, mon_e.addr);
        check("wr_data", 64'(wr_data), 64'(mon_e.data));
        check("done_with_wr", 64'(done), 64'(mon_e.done));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset asserted from time 0; sample mid-cycle
    #2;
    check_idle_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Basic two-word load, back-to-back bytes
    start_load(16'd2);
    check("basic_busy", 64'(busy), 64'd1);
    check("basic_ready", 64'(byte_ready), 64'd1);
    check("basic_done_clr", 64'(done), 64'd0);
    push_exp(64'd0, 32'h91000013, 1'b0);
    push_exp(64'd4, 32'hD2800020, 1'b1);
    send_word(32'h91000013);
    send_word(32'hD2800020);
    send_checksum();
    wait_end();
    check("basic_done", 64'(done), 64'd1);
    check("basic_error", 64'(error), 64'd0);
    check("basic_busy_end", 64'(busy), 64'd0);

    // Same load with 3-cycle gaps between bytes
    start_load(16'd2);
    check("stall_done_clr", 64'(done), 64'd0);
    push_exp(64'd0, 32'h91000013, 1'b0);
    push_exp(64'd4, 32'hD2800020, 1'b1);
    for (int k = 0; k < 8; k++) begin
      logic [63:0] pair;
      pair = 64'hD280002091000013;
      if (k != 0) begin
        repeat (3) begin
          @(negedge clk);
          check("stall_busy", 64'(busy), 64'd1);
        end
      end
      send_byte(pair[8*k +: 8]);
    end
    send_checksum();
    wait_end();
    check("stall_done", 64'(done), 64'd1);

    // Zero-length load
    start_load(16'd0);
    send_checksum();
    wait_end();
    check("zero_done", 64'(done), 64'd1);
    check("zero_error", 64'(error), 64'd0);

    // Out of bounds: 4*257 > 1024
    start_load(16'd257);
    check("oob_error", 64'(error), 64'd1);
    check("oob_done", 64'(done), 64'd0);
    byte_in = 8'hA5;
    byte_valid = 1'b1;
    repeat (4) begin
      check("oob_ready", 64'(byte_ready), 64'd0);
      check("oob_busy", 64'(busy), 64'd0);
      @(negedge clk);
    end
    byte_valid = 1'b0;

    // Exactly full memory: 256 words, last at 1020
    start_load(16'd256);
    check("full_error_clr", 64'(error), 64'd0);
    for (int i = 0; i < 256; i++) begin
      logic [31:0] w;
      w = {8'(i + 3), 8'(i * 5), 8'(i ^ 8'h5A), 8'(i)};
      push_exp(64'(4 * i), w, i == 255);
      send_word(w);
    end
    send_checksum();
    wait_end();
    check("full_done", 64'(done), 64'd1);
    check("full_last_addr", wr_addr, 64'd1020);

    // Reset in the middle of a word discards it
    start_load(16'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #3 reset = 1'b1;
    #1 check_idle_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_load(16'd1);
    push_exp(64'd0, 32'hDDCCBBAA, 1'b1);
    send_word(32'hDDCCBBAA);
    send_checksum();
    wait_end();
    check("midreset_done", 64'(done), 64'd1);

`ifdef LOADER_CHECKSUM_EN
    // Good checksum
    start_load(16'd1);
    push_exp(64'd0, 32'h08040201, 1'b1);
    send_word(32'h08040201);
    check("csum_busy_after_last", 64'(busy), 64'd1);
    send_byte(8'h0F);
    wait_end();
    check("csum_ok_done", 64'(done), 64'd1);
    check("csum_ok_error", 64'(error), 64'd0);
    // Bad checksum: word still written, load fails
    start_load(16'd1);
    push_exp(64'd0, 32'h08040201, 1'b1);
    send_word(32'h08040201);
    send_byte(8'h0E);
    wait_end();
    check("csum_bad_error", 64'(error), 64'd1);
    check("csum_bad_done", 64'(done), 64'd0);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
